// File: rtl/conv7_sequencer.sv
// conv7_sequencer: walks a KxK window across an IMG_W x IMG_H frame, issues
// K kernel rows per output pixel to a convolution engine, then holds each
// engine result on a valid/ready port tagged with its pixel coordinates.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   start_in                one-cycle pulse starting a frame pass (IDLE only)
//   row_num_out             kernel row being issued (0..K-1)
//   win_x_out, win_y_out    window-origin column / source row for the fetch
//   conv_valid_out          row issue strobe to the engine
//   conv_valid_in/data_in   engine result strobe and signed result
//   res_valid_out/ready_in  result handshake
//   res_data_out            held engine result
//   hcount_out, vcount_out  output-pixel coordinates of res_data_out
//   busy_out, done_out      frame in progress / one-cycle completion pulse
//   pad_mask_out            (CONV7_ZERO_PAD_EN only) per-column pad flags
//
// Build option: define CONV7_ZERO_PAD_EN for the zero-padded "same" scan
// (IMG_W x IMG_H outputs, clamped fetch addresses, pad_mask_out port).
// Without it the scan covers only fully-inside windows.

module conv7_sequencer #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 7
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    output logic [3:0]         row_num_out,
    output logic [4:0]         win_x_out,
    output logic [4:0]         win_y_out,
    output logic               conv_valid_out,
    input  logic               conv_valid_in,
    input  logic signed [20:0] conv_data_in,
    output logic               res_valid_out,
    input  logic               res_ready_in,
    output logic signed [20:0] res_data_out,
    output logic [4:0]         hcount_out,
    output logic [4:0]         vcount_out,
    output logic               busy_out,
`ifdef CONV7_ZERO_PAD_EN
    output logic [K-1:0]       pad_mask_out,
`endif
    output logic               done_out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic [3:0] ROW_LAST = 4'(K - 1);

`ifdef CONV7_ZERO_PAD_EN
    localparam int         HALF  = K / 2;
    localparam logic [4:0] X_MAX = 5'(IMG_W - 1);
    localparam logic [4:0] Y_MAX = 5'(IMG_H - 1);
`else
    localparam logic [4:0] X_MAX = 5'(IMG_W - K);
    localparam logic [4:0] Y_MAX = 5'(IMG_H - K);
`endif

    state_t      state;
    state_t      state_nx;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [3:0]  row;
    logic        hs;
    logic        last_px;

    // Handshake completes only while the result is actually being offered.
    assign hs      = (state == EMIT) && res_ready_in;
    assign last_px = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (row == ROW_LAST) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (conv_valid_in) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (res_ready_in) begin
                    state_nx = last_px ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Row counter runs only while issuing and is parked at 0 otherwise,
    // so every pixel starts its issue burst at row 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row <= '0;
        end else if (state == ISSUE && row != ROW_LAST) begin
            row <= row + 4'd1;
        end else begin
            row <= '0;
        end
    end

    // Raster scan position; wraps to (0,0) after the last pixel so the
    // next frame also begins at the origin.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start_in) begin
            x <= '0;
            y <= '0;
        end else if (hs) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? 5'd0 : y + 5'd1;
            end else begin
                x <= x + 5'd1;
            end
        end
    end

    // Engine results are only taken while a pixel is waiting for one.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_data_out <= '0;
        end else if (state == WAIT && conv_valid_in) begin
            res_data_out <= conv_data_in;
        end
    end

    assign row_num_out    = row;
    assign conv_valid_out = (state == ISSUE);
    assign res_valid_out  = (state == EMIT);
    assign busy_out       = (state != IDLE);
    assign done_out       = (state == DONE);
    assign hcount_out     = x;
    assign vcount_out     = y;

`ifdef CONV7_ZERO_PAD_EN
    int org_x;
    int src_y;
    int clp_x;
    int clp_y;

    // Window origin sits K/2 up-left of the output pixel; fetch addresses
    // are clamped into the frame and out-of-frame taps are flagged so the
    // engine can substitute zeros.
    always_comb begin
        org_x = int'(x) - HALF;
        src_y = int'(y) - HALF + int'(row);
        clp_x = org_x;
        clp_y = src_y;
        if (org_x < 0) begin
            clp_x = 0;
        end else if (org_x > IMG_W - 1) begin
            clp_x = IMG_W - 1;
        end
        if (src_y < 0) begin
            clp_y = 0;
        end else if (src_y > IMG_H - 1) begin
            clp_y = IMG_H - 1;
        end
        win_x_out    = 5'(clp_x);
        win_y_out    = 5'(clp_y);
        pad_mask_out = '0;
        if (state == ISSUE) begin
            for (int i = 0; i < K; i++) begin
                pad_mask_out[i] = (src_y < 0) || (src_y > IMG_H - 1) ||
                                  (org_x + i < 0) ||
                                  (org_x + i > IMG_W - 1);
            end
        end
    end
`else
    assign win_x_out = x;
    assign win_y_out = y + 5'(row);
`endif

endmodule

// File: tb/tb_conv7_sequencer.sv
// tb_conv7_sequencer: directed bench for conv7_sequencer; plays the engine
// and result sink, and checks scan order, results, stalls and resets.

module tb_conv7_sequencer;

    localparam int W = 32;
    localparam int H = 32;
    localparam int K = 7;
`ifdef CONV7_ZERO_PAD_EN
    localparam int NX = W;
    localparam int NY = H;
`else
    localparam int NX = W - K + 1;
    localparam int NY = H - K + 1;
`endif
    localparam int NPIX = NX * NY;

    logic               clk_in;
    logic               rst_n_in;
    logic               start_in;
    logic [3:0]         row_num_out;
    logic [4:0]         win_x_out;
    logic [4:0]         win_y_out;
    logic               conv_valid_out;
    logic               conv_valid_in;
    logic signed [20:0] conv_data_in;
    logic               res_valid_out;
    logic               res_ready_in;
    logic signed [20:0] res_data_out;
    logic [4:0]         hcount_out;
    logic [4:0]         vcount_out;
    logic               busy_out;
    logic               done_out;
`ifdef CONV7_ZERO_PAD_EN
    logic [K-1:0]       pad_mask_out;
`endif

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int t0;
    int t_done;

    conv7_sequencer #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .row_num_out   (row_num_out),
        .win_x_out     (win_x_out),
        .win_y_out     (win_y_out),
        .conv_valid_out(conv_valid_out),
        .conv_valid_in (conv_valid_in),
        .conv_data_in  (conv_data_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .busy_out      (busy_out),
`ifdef CONV7_ZERO_PAD_EN
        .pad_mask_out  (pad_mask_out),
`endif
        .done_out      (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial done_cnt = 0;
    always @(negedge clk_in) begin
        if (done_out) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dval(input int n);
        return n * 37 - 5000;
    endfunction

    task automatic pulse_start();
        @(negedge clk_in);
        start_in = 1'b1;
        t0 = cyc;
    endtask

    task automatic serve(input int ex, input int ey, input int n,
                         input int stall, input bit spur,
                         input bit spstart);
        bit hit;
        int wx;
        int wy;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk_in);
            conv_valid_in = 1'b0;
            start_in = 1'b0;
            if (conv_valid_out) begin
`ifdef CONV7_ZERO_PAD_EN
                if (ex == 0 && ey == 0 && row_num_out == 4'd0)
                    check("pad_row0", int'(pad_mask_out), 'h7f);
                if (ex == 0 && ey == 0 && row_num_out == 4'd3)
                    check("pad_row3", int'(pad_mask_out), 'h07);
`endif
                if (spur && row_num_out == 4'd2) begin
                    conv_valid_in = 1'b1;
                    conv_data_in  = 21'h0ABCD;
                end
                if (spstart && row_num_out == 4'd4)
                    start_in = 1'b1;
                if (row_num_out == 4'(K - 1))
                    hit = 1'b1;
            end
        end
        if (!hit) begin
            check("issue_timeout", 0, 1);
            return;
        end
`ifdef CONV7_ZERO_PAD_EN
        wx = (ex - K / 2 < 0) ? 0 : ex - K / 2;
        wy = (ey + K / 2 > H - 1) ? H - 1 : ey + K / 2;
`else
        wx = ex;
        wy = ey + K - 1;
`endif
        check("win_x", int'(win_x_out), wx);
        check("win_y", int'(win_y_out), wy);
        @(negedge clk_in);
        start_in = 1'b0;
        check("wait_no_issue", int'(conv_valid_out), 0);
        conv_valid_in = 1'b1;
        conv_data_in  = 21'(dval(n));
        if (stall > 0)
            res_ready_in = 1'b0;
        @(negedge clk_in);
        conv_valid_in = 1'b0;
        check("emit_valid", int'(res_valid_out), 1);
        check("emit_data", int'(res_data_out), dval(n));
        check("emit_h", int'(hcount_out), ex);
        check("emit_v", int'(vcount_out), ey);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_in);
            check("stall_valid", int'(res_valid_out), 1);
            check("stall_data", int'(res_data_out), dval(n));
            check("stall_h", int'(hcount_out), ex);
            check("stall_v", int'(vcount_out), ey);
            check("stall_no_issue", int'(conv_valid_out), 0);
        end
        res_ready_in = 1'b1;
    endtask

    task automatic run_frame(input int fid);
        for (int n = 0; n < NPIX; n++) begin
            serve(n % NX, n / NX, n,
                  (fid == 2 && n == 3) ? 5 : 0,
                  fid == 2 && n == 1,
                  fid == 2 && n == 2);
        end
        @(negedge clk_in);
        check("done_pulse", int'(done_out), 1);
        check("done_busy", int'(busy_out), 1);
        @(negedge clk_in);
        check("done_clear", int'(done_out), 0);
        check("idle_busy", int'(busy_out), 0);
    endtask

    initial begin
        bit hit;
        checks        = 0;
        errors        = 0;
        rst_n_in      = 1'b0;
        start_in      = 1'b0;
        conv_valid_in = 1'b0;
        conv_data_in  = '0;
        res_ready_in  = 1'b1;
        #12;
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(done_out), 0);
        check("rst_cv", int'(conv_valid_out), 0);
        check("rst_rv", int'(res_valid_out), 0);
        check("rst_row", int'(row_num_out), 0);
        check("rst_data", int'(res_data_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        pulse_start();
        run_frame(1);
        check("frame_cycles", t_done - t0, NPIX * 9 + 1);
        check("done_count1", done_cnt, 1);

        pulse_start();
        run_frame(2);
        check("done_count2", done_cnt, 2);

        pulse_start();
        serve(0, 0, 0, 0, 1'b0, 1'b0);
        serve(1, 0, 1, 0, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk_in);
            if (conv_valid_out && row_num_out == 4'd3)
                hit = 1'b1;
        end
        check("reach_row3", int'(hit), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_row", int'(row_num_out), 0);
        check("arst_wx", int'(win_x_out), 0);
        check("arst_wy", int'(win_y_out), 0);
        check("arst_cv", int'(conv_valid_out), 0);
        check("arst_rv", int'(res_valid_out), 0);
        check("arst_busy", int'(busy_out), 0);
        check("arst_done", int'(done_out), 0);
        check("arst_data", int'(res_data_out), 0);
        check("arst_h", int'(hcount_out), 0);
        check("arst_v", int'(vcount_out), 0);
        repeat (3) @(negedge clk_in);
        check("arst_no_done", done_cnt, 2);
        rst_n_in = 1'b1;
        start_in = 1'b1;
        t0 = cyc;
        run_frame(4);
        check("frame_cycles4", t_done - t0, NPIX * 9 + 1);
        check("done_count3", done_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
